// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter with registered one-hot grant and
// address/data-phase owner tracking; bursts and locked sequences run to completion.
module ahb_rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0,
    parameter int MST_W   = 4
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq_i,
    input  logic [NUM_MST-1:0] hlock_i,
    input  logic [1:0]         htrans_i,
    input  logic [2:0]         hburst_i,
    input  logic               hready_i,
    input  logic [1:0]         hresp_i,
    output logic [NUM_MST-1:0] hgrant_o,
    output logic [MST_W-1:0]   hmaster_o,
    output logic [MST_W-1:0]   hmaster_wd_o,
    output logic               hmastlock_o
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    localparam logic [NUM_MST-1:0] DEF_GNT = NUM_MST'(1) << DEF_MST;
    localparam logic [MST_W-1:0]   DEF_IDX = MST_W'(DEF_MST);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [MST_W-1:0]   rr_q, rr_d;
    logic [NUM_MST-1:0] gnt_q, gnt_d;
    logic [MST_W-1:0]   mst_q, mst_d;
    logic [MST_W-1:0]   mst_wd_q, mst_wd_d;
    logic               lock_q, lock_d;

    logic [MST_W-1:0]   gnt_idx;
    logic               gnt_lock;
    logic               accept;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_dec;
    logic [3:0]         load_val;
    logic [NUM_MST-1:0] arb_gnt;
    logic               arb_hit;
    int                 pos;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = MST_W'(i);
            end
        end
    end

    // Grant is one-hot, so masking the lock vector picks the granted master's bit.
    assign gnt_lock = |(gnt_q & hlock_i);

    assign accept   = hready_i & htrans_i[1];
    assign cnt_clr  = (hready_i && htrans_i == 2'b00)
                   || (!hready_i && hresp_i != 2'b00);
    assign cnt_load = accept & ~htrans_i[0];
    assign cnt_dec  = accept & htrans_i[0] & (cnt_q != 4'd0);

    always_comb begin
        load_val = 4'd0;
        unique case (hburst_i)
            3'd2, 3'd3: load_val = 4'd3;
            3'd4, 3'd5: load_val = 4'd7;
            3'd6, 3'd7: load_val = 4'd15;
            default:    load_val = 4'd0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = 4'd0;
        end else if (cnt_load) begin
            cnt_d = load_val;
        end else if (cnt_dec) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARB: begin
                if (gnt_lock) begin
                    state_d = ST_LOCK;
                end else if (cnt_load && load_val > 4'd1) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (gnt_lock) begin
                    state_d = ST_LOCK;
                end else if (cnt_d <= 4'd1) begin
                    state_d = ST_ARB;
                end
            end
            ST_LOCK: begin
                if (!gnt_lock) begin
                    state_d = (cnt_d > 4'd1) ? ST_BURST : ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Search starts after the pointer value this edge commits, so a
    // ready bus rotates one master per cycle and a stalled bus holds its pick.
    assign rr_d = hready_i ? gnt_idx : rr_q;

    always_comb begin
        arb_gnt = DEF_GNT;
        arb_hit = 1'b0;
        pos     = 0;
        for (int k = 1; k <= NUM_MST; k++) begin
            pos = (int'(rr_d) + k) % NUM_MST;
            if (!arb_hit && (hbusreq_i & (NUM_MST'(1) << pos)) != '0) begin
                arb_hit = 1'b1;
                arb_gnt = NUM_MST'(1) << pos;
            end
        end
    end

    always_comb begin
        gnt_d    = gnt_q;
        mst_d    = mst_q;
        mst_wd_d = mst_wd_q;
        lock_d   = lock_q;
        if (state_d == ST_ARB) begin
            gnt_d = arb_gnt;
        end
        if (hready_i) begin
            mst_d    = gnt_idx;
            mst_wd_d = mst_q;
            lock_d   = gnt_lock;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_ARB;
            cnt_q    <= 4'd0;
            rr_q     <= DEF_IDX;
            gnt_q    <= DEF_GNT;
            mst_q    <= DEF_IDX;
            mst_wd_q <= DEF_IDX;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            mst_q    <= mst_d;
            mst_wd_q <= mst_wd_d;
            lock_q   <= lock_d;
        end
    end

    assign hgrant_o     = gnt_q;
    assign hmaster_o    = mst_q;
    assign hmaster_wd_o = mst_wd_q;
    assign hmastlock_o  = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against a rule-level reference model.
module tb_ahb_rr_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [N-1:0] req;
    logic [N-1:0] lck;
    logic [1:0]   trans;
    logic [2:0]   burst;
    logic         rdy;
    logic [1:0]   resp;
    logic [N-1:0] hgrant_o;
    logic [3:0]   hmaster_o;
    logic [3:0]   hmaster_wd_o;
    logic         hmastlock_o;

    int n_cmp = 0;
    int n_err = 0;

    int m_grant;
    int m_master;
    int m_wd;
    int m_lock;
    int m_cnt;
    int m_rr;

    logic [3:0] rot [6] = '{4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1};

    ahb_rr_arbiter #(
        .NUM_MST(N),
        .DEF_MST(DEF),
        .MST_W  (4)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hbusreq_i   (req),
        .hlock_i     (lck),
        .htrans_i    (trans),
        .hburst_i    (burst),
        .hready_i    (rdy),
        .hresp_i     (resp),
        .hgrant_o    (hgrant_o),
        .hmaster_o   (hmaster_o),
        .hmaster_wd_o(hmaster_wd_o),
        .hmastlock_o (hmastlock_o)
    );

    always #5 hclk = ~hclk;

    function automatic int bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return int'(t[0]);
    endfunction

    function automatic int beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_wd     = DEF;
        m_lock   = 0;
        m_cnt    = 0;
        m_rr     = DEF;
    endtask

    // One clock edge of the arbiter, using the inputs held before the edge.
    task automatic model_edge();
        int  ncnt;
        int  ptr;
        int  ngrant;
        int  cand;
        bit  found;
        ncnt = m_cnt;
        if (!rdy && resp != 2'd0)
            ncnt = 0;
        else if (rdy && trans == 2'd0)
            ncnt = 0;
        else if (rdy && trans == 2'd2)
            ncnt = beats(burst) - 1;
        else if (rdy && trans == 2'd3 && m_cnt > 0)
            ncnt = m_cnt - 1;
        ngrant = m_grant;
        if (bit_of(lck, m_grant) == 0 && ncnt <= 1) begin
            ptr    = rdy ? m_grant : m_rr;
            ngrant = DEF;
            found  = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (ptr + k) % N;
                if (!found && bit_of(req, cand) == 1) begin
                    found  = 1'b1;
                    ngrant = cand;
                end
            end
        end
        if (rdy) begin
            m_wd     = m_master;
            m_master = m_grant;
            m_rr     = m_grant;
            m_lock   = bit_of(lck, m_grant);
        end
        m_grant = ngrant;
        m_cnt   = ncnt;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] g;
        g = 32'd1 << m_grant;
        check({tag, "_grant"}, 32'(hgrant_o), g);
        check({tag, "_onehot"}, 32'($onehot(hgrant_o)), 32'd1);
        check({tag, "_master"}, 32'(hmaster_o), 32'(m_master));
        check({tag, "_master_wd"}, 32'(hmaster_wd_o), 32'(m_wd));
        check({tag, "_mastlock"}, 32'(hmastlock_o), 32'(m_lock));
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [1:0] t, input logic [2:0] b,
                         input logic y, input logic [1:0] s);
        req   = r;
        lck   = l;
        trans = t;
        burst = b;
        rdy   = y;
        resp  = s;
    endtask

    task automatic step(input string tag);
        @(posedge hclk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        hresetn = 1'b0;
        drive(4'h0, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        model_reset();
        #12;
        check("rst_grant", 32'(hgrant_o), 32'h1);
        check("rst_master", 32'(hmaster_o), 32'h0);
        check("rst_master_wd", 32'(hmaster_wd_o), 32'h0);
        check("rst_mastlock", 32'(hmastlock_o), 32'h0);
        hresetn = 1'b1;

        // Idle bus parks on the default master
        repeat (2) step("idle");
        check("idle_grant", 32'(hgrant_o), 32'h1);

        // Three simultaneous single-transfer requesters rotate
        drive(4'b0111, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        for (int i = 0; i < 6; i++) begin
            step("rot");
            check("rot_seq", 32'(hgrant_o), 32'(rot[i]));
        end

        // M1 INCR8 with M2 waiting, two wait states inside
        drive(4'b0010, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        repeat (3) step("b8_setup");
        drive(4'b0110, 4'h0, 2'd2, 3'd5, 1'b1, 2'd0);
        step("b8_beat1");
        trans = 2'd3;
        repeat (2) step("b8_beat");
        rdy = 1'b0;
        repeat (2) step("b8_wait");
        rdy = 1'b1;
        repeat (3) step("b8_beat");
        check("b8_grant_beat6", 32'(hgrant_o), 32'h2);
        step("b8_beat7");
        check("b8_grant_beat7", 32'(hgrant_o), 32'h4);
        step("b8_beat8");
        check("b8_master_after", 32'(hmaster_o), 32'h2);
        check("b8_master_wd_after", 32'(hmaster_wd_o), 32'h1);

        // M3 locked across two INCR4 bursts while M0 requests
        drive(4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1, 2'd0);
        repeat (3) step("lk_setup");
        req = 4'b1001;
        for (int b = 0; b < 2; b++) begin
            trans = 2'd2;
            burst = 3'd3;
            for (int s = 0; s < 4; s++) begin
                step("lk_beat");
                check("lk_grant", 32'(hgrant_o), 32'h8);
                check("lk_mastlock", 32'(hmastlock_o), 32'h1);
                trans = 2'd3;
            end
        end
        drive(4'b1001, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        step("lk_release");
        check("lk_grant_m0", 32'(hgrant_o), 32'h1);

        // M1 INCR16 retried at beat 5
        drive(4'b0010, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        repeat (3) step("rt_setup");
        drive(4'b0110, 4'h0, 2'd2, 3'd7, 1'b1, 2'd0);
        step("rt_beat1");
        trans = 2'd3;
        repeat (3) step("rt_beat");
        drive(4'b0110, 4'h0, 2'd3, 3'd7, 1'b0, 2'd2);
        step("rt_retry1");
        check("rt_grant_m2", 32'(hgrant_o), 32'h4);
        check("rt_master_hold", 32'(hmaster_o), 32'h1);
        drive(4'b0110, 4'h0, 2'd0, 3'd7, 1'b1, 2'd2);
        step("rt_retry2");
        check("rt_master_m2", 32'(hmaster_o), 32'h2);
        resp = 2'd0;

        // Asynchronous reset in the middle of an INCR4
        drive(4'b0010, 4'h0, 2'd0, 3'd0, 1'b1, 2'd0);
        repeat (2) step("ar_setup");
        drive(4'b0010, 4'h0, 2'd2, 3'd3, 1'b1, 2'd0);
        step("ar_beat1");
        trans = 2'd3;
        step("ar_beat2");
        hresetn = 1'b0;
        #2;
        model_reset();
        check("ar_grant", 32'(hgrant_o), 32'h1);
        check("ar_master", 32'(hmaster_o), 32'h0);
        check("ar_master_wd", 32'(hmaster_wd_o), 32'h0);
        check("ar_mastlock", 32'(hmastlock_o), 32'h0);
        #1;
        hresetn = 1'b1;
        drive(4'b0110, 4'h0, 2'd1, 3'd0, 1'b1, 2'd0);
        step("ar_post1");
        check("ar_post_grant1", 32'(hgrant_o), 32'h2);
        step("ar_post2");
        check("ar_post_grant2", 32'(hgrant_o), 32'h4);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive(4'($urandom),
                  ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0,
                  2'($urandom),
                  3'($urandom),
                  $urandom_range(3) != 0,
                  ($urandom_range(7) == 0) ? 2'($urandom) : 2'd0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
